// File: rtl/jtpang_pkg.sv
// Shared constants for the jtpang object DMA: default table geometry and
// the state encoding of the DMA sequencer.
package jtpang_pkg;

    // Default DMA address width (table of 2^AW bytes) and final source address.
    localparam int         OBJDMA_AW   = 9;
    localparam logic [8:0] OBJDMA_LAST = 9'h1FF;

    // DMA sequencer states.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

endpackage

// File: rtl/jtpang_objdma.sv
// jtpang_objdma: copies the object table from VRAM into an object line
// buffer while holding the CPU off the bus.
//
// Optional feature: define JTPANG_OBJDMA_DBUF_EN to double-buffer the object
// table. The renderer then reads bank disp_bank while the DMA writes the other
// bank, and the banks swap on the LVBL falling edge after a completed
// transfer. Without the macro a single bank (MSB 0) is used and LVBL is
// ignored.
//
// Handshake: busrq is held high from trigger acceptance until the final byte
// is written. The CPU grants the bus by driving busak_n low; every cen with
// busak_n low advances the source address by one. dma_din is the VRAM read
// data for the address presented one cen earlier. busak_n returning high
// stalls the transfer without losing data. buf_we is a one-clk strobe with
// buf_addr/buf_din valid in the same cycle.
module jtpang_objdma
    import jtpang_pkg::*;
#(
    parameter int            AW   = OBJDMA_AW,
    parameter logic [AW-1:0] LAST = AW'(OBJDMA_LAST)
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          dma_go,
    input  logic          LVBL,
    input  logic          busak_n,
    output logic          busrq,
    output logic [AW-1:0] dma_addr,
    input  logic [7:0]    dma_din,
    output logic          buf_we,
    output logic [AW:0]   buf_addr,
    output logic [7:0]    buf_din,
    output logic          disp_bank,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    logic [1:0]    state;
    logic          go_l;       // previous dma_go, for rising-edge detection
    logic          pending;    // trigger seen but not yet accepted
    logic          primed;     // first address of this transfer already read
    logic          fresh;      // dma_din holds the byte for dma_addr-1
    logic [7:0]    din_q;      // byte for dma_addr-1 captured before a stall
    logic          wr_bank;

    logic          go_edge;
    logic          start;
    logic          take;
    logic          flush_done;
    logic [AW-1:0] prev_addr;
    logic [7:0]    wr_data;

    assign go_edge    = dma_go & ~go_l;
    assign start      = cen & (state == ST_IDLE) & (pending | go_edge);
    assign take       = cen & ~busak_n & (state == ST_XFER);
    assign flush_done = cen & (state == ST_FLUSH);
    assign prev_addr  = dma_addr - AW'(1);
    // After a bus stall the VRAM output already follows the frozen address,
    // so the byte for dma_addr-1 comes from the copy taken when it was valid.
    assign wr_data    = fresh ? dma_din : din_q;

    assign busrq      = (state != ST_IDLE);
    assign busy       = (state != ST_IDLE) | pending;
    assign dbg_state  = state;

    // Trigger edge detection and the single-entry pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            go_l    <= 1'b0;
            pending <= 1'b0;
        end else begin
            go_l <= dma_go;
            if (start)
                pending <= 1'b0;
            else if (go_edge)
                pending <= 1'b1;
        end
    end

    // DMA sequencer: address generation and state, advanced only on cen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            dma_addr <= '0;
            primed   <= 1'b0;
            fresh    <= 1'b0;
            din_q    <= 8'd0;
        end else if (cen) begin
            fresh <= 1'b0;
            if (fresh)
                din_q <= dma_din;
            case (state)
                ST_IDLE: begin
                    if (pending || go_edge) begin
                        state    <= ST_REQ;
                        dma_addr <= '0;
                        primed   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (!busak_n)
                        state <= ST_XFER;
                end
                ST_XFER: begin
                    if (!busak_n) begin
                        primed <= 1'b1;
                        fresh  <= 1'b1;
                        if (dma_addr == LAST)
                            state <= ST_FLUSH;
                        else
                            dma_addr <= dma_addr + AW'(1);
                    end
                end
                ST_FLUSH: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Object buffer write port: one strobe per accepted byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_we   <= 1'b0;
            buf_addr <= '0;
            buf_din  <= 8'd0;
        end else begin
            buf_we <= 1'b0;
            if (take && primed) begin
                buf_we   <= 1'b1;
                buf_addr <= {wr_bank, prev_addr};
                buf_din  <= wr_data;
            end else if (flush_done) begin
                buf_we   <= 1'b1;
                buf_addr <= {wr_bank, LAST};
                buf_din  <= wr_data;
            end
        end
    end

`ifdef JTPANG_OBJDMA_DBUF_EN
    logic lvbl_l;
    logic done;
    logic lvbl_fall;

    assign lvbl_fall = lvbl_l & ~LVBL;
    assign wr_bank   = ~disp_bank;

    // Bank swap at the start of vertical blank once a fresh table is ready;
    // a completion landing on the swap edge is kept for the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvbl_l    <= 1'b0;
            done      <= 1'b0;
            disp_bank <= 1'b0;
        end else begin
            lvbl_l <= LVBL;
            if (lvbl_fall && done)
                disp_bank <= ~disp_bank;
            if (flush_done)
                done <= 1'b1;
            else if (lvbl_fall)
                done <= 1'b0;
        end
    end
`else
    logic unused_lvbl;

    assign unused_lvbl = LVBL;
    assign disp_bank   = 1'b0;
    assign wr_bank     = 1'b0;
`endif

endmodule

// File: tb/tb_jtpang_objdma.sv
// Self-checking bench for jtpang_objdma. Honours JTPANG_OBJDMA_DBUF_EN to
// select the expected bank behaviour.
module tb_jtpang_objdma;
  localparam int AW    = 9;
  localparam int NBYTE = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cen = 1'b0;
  logic          dma_go = 1'b0;
  logic          LVBL = 1'b1;
  logic          busak_n = 1'b1;
  logic          busrq;
  logic [AW-1:0] dma_addr;
  logic [7:0]    dma_din = 8'd0;
  logic          buf_we;
  logic [AW:0]   buf_addr;
  logic [7:0]    buf_din;
  logic          disp_bank;
  logic          busy;
  logic [1:0]    dbg_state;

  logic [7:0]    vram [0:NBYTE-1];
  logic [AW+8:0] exp_q [$];
  int            n_tests = 0;
  int            n_fail = 0;
  int            n_writes = 0;
  int            cen_cnt = 0;
  bit            in_gap = 1'b0;
  bit            gap_en = 1'b0;
  bit            model_disp = 1'b0;
  bit            model_done = 1'b0;

  jtpang_objdma dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .dma_go    (dma_go),
    .LVBL      (LVBL),
    .busak_n   (busak_n),
    .busrq     (busrq),
    .dma_addr  (dma_addr),
    .dma_din   (dma_din),
    .buf_we    (buf_we),
    .buf_addr  (buf_addr),
    .buf_din   (buf_din),
    .disp_bank (disp_bank),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock, cen every third clk, VRAM with one-cen read latency
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cen_cnt <= (cen_cnt == 2) ? 0 : cen_cnt + 1;
    cen     <= (cen_cnt == 1);
    if (cen) dma_din <= vram[dma_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // returns #1 after a posedge when the next posedge carries cen
  task automatic wait_cen_edge();
    do begin
      @(posedge clk);
      #1;
    end while (!cen);
  endtask

  function automatic logic exp_bank();
`ifdef JTPANG_OBJDMA_DBUF_EN
    return ~model_disp;
`else
    return 1'b0;
`endif
  endfunction

  task automatic new_vram();
    for (int i = 0; i < NBYTE; i++) vram[i] = 8'($urandom_range(0, 255));
  endtask

  // reference: a complete transfer writes every table byte, in order
  task automatic push_transfer();
    for (int a = 0; a < NBYTE; a++) exp_q.push_back({exp_bank(), AW'(a), vram[a]});
  endtask

  task automatic trigger();
    push_transfer();
    dma_go = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    dma_go = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      wait_cen_edge();
      n++;
    end
    check({name, "_busy_low"}, 32'(busy), 0);
    check({name, "_busrq_low"}, 32'(busrq), 0);
    check({name, "_writes_left"}, exp_q.size(), 0);
  endtask

  task automatic wait_addr(input string name, input logic [AW-1:0] a, input int budget);
    int n = 0;
    while (dma_addr != a && n < budget) begin
      wait_cen_edge();
      n++;
    end
    check(name, 32'(dma_addr), 32'(a));
  endtask

  task automatic lvbl_fall(input string name);
    LVBL = 1'b0;
`ifdef JTPANG_OBJDMA_DBUF_EN
    if (model_done) begin
      model_disp = ~model_disp;
      model_done = 1'b0;
    end
`endif
    repeat (3) @(posedge clk);
    #1;
    check(name, 32'(disp_bank), 32'(model_disp));
    LVBL = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // scoreboard monitor: every write strobe must match the head of exp_q
  always @(negedge clk) begin
    logic [AW+8:0] e;
    if (buf_we) begin
      n_writes++;
      if (in_gap) check("we_during_gap", 32'(in_gap), 0);
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", buf_addr, buf_din);
      end else begin
        e = exp_q.pop_front();
        if ({buf_addr, buf_din} !== e) begin
          n_fail++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   buf_addr, buf_din, e[AW+8:8], e[7:0]);
        end
      end
    end
  end

  // CPU bus agent: grants two cens after busrq, optional 10-cen stall at 0x080
  initial begin : bus_agent
    forever begin
      @(posedge clk);
      #1;
      if (busrq) begin
        wait_cen_edge();
        wait_cen_edge();
        if (busrq) busak_n = 1'b0;
        while (busrq) begin
          wait_cen_edge();
          if (!busrq) break;
          if (gap_en && dma_addr == 9'h080 && busak_n == 1'b0) begin
            busak_n = 1'b1;
            in_gap  = 1'b1;
            gap_en  = 1'b0;
            repeat (10) wait_cen_edge();
            in_gap  = 1'b0;
            busak_n = 1'b0;
          end
        end
        busak_n = 1'b1;
      end
    end
  end

  initial begin : main
    int n0;
    for (int i = 0; i < NBYTE; i++) vram[i] = 8'd0;

    // reset state
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_busrq", 32'(busrq), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_buf_we", 32'(buf_we), 0);
    check("rst_dma_addr", 32'(dma_addr), 0);
    check("rst_buf_addr", 32'(buf_addr), 0);
    check("rst_buf_din", 32'(buf_din), 0);
    check("rst_disp_bank", 32'(disp_bank), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // plain full transfer
    new_vram();
    trigger();
    check("xfer1_busy", 32'(busy), 1);
    wait_cen_edge();
    check("xfer1_busrq", 32'(busrq), 1);
    wait_idle("xfer1", 700);
    model_done = 1'b1;

    // bank swap after a completed transfer, then an edge with nothing new
    lvbl_fall("lvbl_swap");
    lvbl_fall("lvbl_no_swap");

    // transfer with a 10-cen bus stall at 0x080
    new_vram();
    gap_en = 1'b1;
    n0 = n_writes;
    trigger();
    wait_idle("gap", 700);
    check("gap_write_count", n_writes - n0, NBYTE);
    model_done = 1'b1;

    // asynchronous reset in the middle of a transfer
    new_vram();
    trigger();
    wait_addr("rst_reach_100", 9'h100, 700);
    rst_n = 1'b0;
    #1;
    check("midrst_busrq", 32'(busrq), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_dma_addr", 32'(dma_addr), 0);
    check("midrst_disp_bank", 32'(disp_bank), 0);
    exp_q.delete();
    model_disp = 1'b0;
    model_done = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    n0 = n_writes;
    repeat (40) wait_cen_edge();
    check("postrst_writes", n_writes - n0, 0);
    check("postrst_busrq", 32'(busrq), 0);

    // two further triggers during a transfer give exactly one extra transfer
    new_vram();
    trigger();
    wait_addr("pend_reach_040", 9'h040, 700);
    push_transfer();
    dma_go = 1'b1;
    repeat (2) @(posedge clk);
    dma_go = 1'b0;
    repeat (2) @(posedge clk);
    dma_go = 1'b1;
    repeat (2) @(posedge clk);
    dma_go = 1'b0;
    #1;
    check("pend_busy", 32'(busy), 1);
    wait_idle("pend", 1400);
    n0 = n_writes;
    repeat (30) wait_cen_edge();
    check("pend_no_third_busrq", 32'(busrq), 0);
    check("pend_no_third_writes", n_writes - n0, 0);
    model_done = 1'b1;

    lvbl_fall("lvbl_swap2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
